// File: rtl/reg_sequencer.sv
// reg_sequencer: command-driven micro-sequencer that steps an external
// shift/count register through CLR, LOAD, INC, DEC, SHR, SHL, ROR, ROL
// and ASR operations by raising one control strobe per cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (accept = valid && ready)
//   cmd_op, cmd_cnt       opcode and iteration count
//   cmd_data              LOAD value
//   reg_q                 current value of the controlled register
//   cl, ld, inc, dec,
//   sr, sl                register control strobes (at most one high)
//   ir, il                serial bits shifted in on sr / sl
//   reg_d                 parallel-load value for the register
//   busy, done, err       status; err qualifies the one-cycle done pulse
module reg_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] reg_q,
  output logic                  cl,
  output logic                  ld,
  output logic                  inc,
  output logic                  dec,
  output logic                  sr,
  output logic                  sl,
  output logic                  ir,
  output logic                  il,
  output logic [DATA_WIDTH-1:0] reg_d,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_CLR  = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_LOAD = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_INC  = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_DEC  = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_SHR  = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_SHL  = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_ROR  = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_ROL  = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_ASR  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  // Only the end bits of reg_q feed the serial inputs; fold the rest away.
  logic unused_reg_bits;
  assign unused_reg_bits = ^reg_q[DATA_WIDTH-2:1];

  // State and latched command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      op_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept in IDLE, count iterations in EXEC, single DONE cycle.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          err_d  = 1'b0;
          unique case (cmd_op)
            OP_CLR, OP_LOAD: begin
              rem_d   = CNT_WIDTH'(1);
              state_d = S_EXEC;
            end
            OP_INC, OP_DEC, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: begin
              rem_d   = cmd_cnt;
              state_d = (cmd_cnt != '0) ? S_EXEC : S_DONE;
            end
            default: begin
              rem_d   = '0;
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_EXEC: begin
        rem_d = rem_q - CNT_WIDTH'(1);
        if (rem_q == CNT_WIDTH'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from registered state; serial bits follow reg_q live.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    err       = (state_q == S_DONE) && err_q;
    cl        = 1'b0;
    ld        = 1'b0;
    inc       = 1'b0;
    dec       = 1'b0;
    sr        = 1'b0;
    sl        = 1'b0;
    ir        = 1'b0;
    il        = 1'b0;
    reg_d     = '0;
    if (state_q == S_EXEC) begin
      unique case (op_q)
        OP_CLR:  cl = 1'b1;
        OP_LOAD: begin
          ld    = 1'b1;
          reg_d = data_q;
        end
        OP_INC:  inc = 1'b1;
        OP_DEC:  dec = 1'b1;
        OP_SHR:  sr  = 1'b1;
        OP_ROR: begin
          sr = 1'b1;
          ir = reg_q[0];
        end
        OP_ASR: begin
          sr = 1'b1;
          ir = reg_q[DATA_WIDTH-1];
        end
        OP_SHL:  sl = 1'b1;
        OP_ROL: begin
          sl = 1'b1;
          il = reg_q[DATA_WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: a bench-side register obeys the strobes, and a
// timeline model (accept cycle + iteration count) predicts every output
// and the final register value computed arithmetically per opcode.
module tb_reg_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [CW-1:0] cmd_cnt = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] reg_val = '0;
  logic          cl, ld, inc, dec, sr, sl, ir, il;
  logic [DW-1:0] reg_d;
  logic          busy, done, err;

  int total = 0;
  int bad = 0;

  reg_sequencer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .reg_q(reg_val),
    .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
    .ir(ir), .il(il), .reg_d(reg_d),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Controlled register: reacts to whichever strobe the sequencer raises.
  always @(posedge clk) begin
    if (cl)       reg_val <= '0;
    else if (ld)  reg_val <= reg_d;
    else if (inc) reg_val <= reg_val + 16'd1;
    else if (dec) reg_val <= reg_val - 16'd1;
    else if (sr)  reg_val <= {ir, reg_val[DW-1:1]};
    else if (sl)  reg_val <= {reg_val[DW-2:0], il};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Register value after n iterations of op starting from r.
  function automatic logic [DW-1:0] calc(input logic [3:0] op, input int n,
                                         input logic [DW-1:0] r, input logic [DW-1:0] d);
    logic [31:0] w;
    w = {r, r};
    case (op)
      4'd0: return '0;
      4'd1: return d;
      4'd2: return r + 16'(n);
      4'd3: return r - 16'(n);
      4'd4: return r >> n;
      4'd5: return r << n;
      4'd6: return 16'(w >> n);
      4'd7: begin
        w = w << n;
        return w[31:16];
      end
      4'd8: return 16'($signed(r) >>> n);
      default: return r;
    endcase
  endfunction

  // Timeline model: cycle index cyc; command accepted at end of cycle m_t.
  int            cyc = 0;
  bit            m_act = 1'b0;
  int            m_t = 0;
  int            m_n = 0;
  logic [3:0]    m_op = '0;
  bit            m_ill = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_final = '0;
  int            acc_count = 0;
  int            last_t = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0;
    end else begin
      if ((!m_act || (cyc - m_t) >= m_n + 2) && cmd_valid) begin
        m_act  = 1'b1;
        m_t    = cyc;
        m_op   = cmd_op;
        m_ill  = (cmd_op > 4'd8);
        m_data = cmd_data;
        if (m_ill)                m_n = 0;
        else if (cmd_op <= 4'd1)  m_n = 1;
        else                      m_n = int'(cmd_cnt);
        m_final   = m_ill ? reg_val : calc(cmd_op, m_n, reg_val, cmd_data);
        acc_count = acc_count + 1;
        last_t    = cyc;
      end
      cyc = cyc + 1;
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int   k;
    bit   exec_ph, done_ph;
    logic [5:0] e_strb;
    logic e_ir, e_il;
    k       = cyc - m_t;
    exec_ph = rst_n && m_act && k >= 1 && k <= m_n;
    done_ph = rst_n && m_act && k == m_n + 1;
    e_strb  = '0;
    e_ir    = 1'b0;
    e_il    = 1'b0;
    if (exec_ph) begin
      case (m_op)
        4'd0: e_strb = 6'b100000;
        4'd1: e_strb = 6'b010000;
        4'd2: e_strb = 6'b001000;
        4'd3: e_strb = 6'b000100;
        4'd4, 4'd6, 4'd8: e_strb = 6'b000010;
        default: e_strb = 6'b000001;
      endcase
      if (m_op == 4'd6) e_ir = reg_val[0];
      if (m_op == 4'd8) e_ir = reg_val[DW-1];
      if (m_op == 4'd7) e_il = reg_val[DW-1];
    end
    chk("strobes", {cl, ld, inc, dec, sr, sl}, e_strb);
    chk("ir", ir, e_ir);
    chk("il", il, e_il);
    chk("reg_d", reg_d, (exec_ph && m_op == 4'd1) ? m_data : '0);
    chk("cmd_ready", cmd_ready, !(exec_ph || done_ph));
    chk("busy", busy, exec_ph || done_ph);
    chk("done", done, done_ph);
    chk("err", err, done_ph && m_ill);
    if (done_ph) chk("reg_final", reg_val, m_final);
  end

  // Offer a command, wait for acceptance and completion (both bounded).
  task automatic issue(input logic [3:0] op, input logic [CW-1:0] cnt,
                       input logic [DW-1:0] data, input bit hold);
    int  a0;
    bit  got;
    a0        = acc_count;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_valid = 1'b1;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (acc_count != a0) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL accept_timeout: op %0h not accepted in 40 cycles", op);
    end
    if (!hold) cmd_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL done_timeout: op %0h no done in 40 cycles", op);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1;
    int a0;
    logic [3:0]    rop;
    logic [CW-1:0] rcnt;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {cl, ld, inc, dec, sr, sl, ir, il}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(4'd1, 4'd0, 16'h1234, 1'b0);
    chk("load_1234", reg_val, 16'h1234);
    issue(4'd1, 4'd0, 16'h0001, 1'b0);
    issue(4'd5, 4'd3, 16'h0000, 1'b0);
    chk("shl3", reg_val, 16'h0008);
    issue(4'd1, 4'd0, 16'h8001, 1'b0);
    issue(4'd6, 4'd1, 16'h0000, 1'b0);
    chk("ror1", reg_val, 16'hC000);
    issue(4'd1, 4'd0, 16'h8000, 1'b0);
    issue(4'd8, 4'd2, 16'h0000, 1'b0);
    chk("asr2", reg_val, 16'hE000);
    issue(4'd2, 4'd0, 16'h0000, 1'b0);
    chk("inc0_keeps", reg_val, 16'hE000);
    issue(4'hF, 4'd5, 16'h0000, 1'b0);
    chk("illegal_keeps", reg_val, 16'hE000);

    // Wrap with cmd_valid held high across two commands.
    issue(4'd1, 4'd0, 16'hFFFF, 1'b0);
    issue(4'd2, 4'd2, 16'h0000, 1'b1);
    t1 = last_t;
    chk("inc_wrap", reg_val, 16'h0001);
    issue(4'd7, 4'd15, 16'h0000, 1'b0);
    chk("b2b_gap", 32'(last_t - t1), 32'd4);
    chk("rol15", reg_val, 16'h8000);

    // Reset in the 4th EXEC cycle of DEC cnt=10.
    issue(4'd1, 4'd0, 16'h0100, 1'b0);
    a0        = acc_count;
    cmd_op    = 4'd3;
    cmd_cnt   = 4'd10;
    cmd_valid = 1'b1;
    for (int i = 0; i < 40 && acc_count == a0; i++) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_strobes", {cl, ld, inc, dec, sr, sl}, 6'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_reg", reg_val, 16'h00FD);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'd1, 4'd0, 16'hA5A5, 1'b0);
    chk("load_after_rst", reg_val, 16'hA5A5);

    for (int i = 0; i < 40; i++) begin
      rop  = 4'($urandom_range(0, 11));
      rcnt = (i < 3) ? 4'd15 : 4'($urandom_range(0, 15));
      issue(rop, rcnt, 16'($urandom), 1'($urandom_range(0, 1)));
      cmd_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
